// File: rtl/usb_capture_pkg.sv
// Shared constants and full-policy encoding for the USB sniffer capture FIFO.
package usb_capture_pkg;

  localparam int unsigned CAPTURE_DATA_W     = 32;
  localparam int unsigned CAPTURE_DEPTH      = 8192;
  localparam int unsigned CAPTURE_DROP_CNT_W = 16;

  typedef enum logic {
    CAPTURE_STALL = 1'b0,
    CAPTURE_DROP  = 1'b1
  } capture_policy_e;

endpackage

// File: rtl/usb_capture_fifo_if.sv
// Stream-in / register-read bundle of the capture FIFO; master = sniffer/reader side, slave = FIFO.
interface usb_capture_fifo_if
  import usb_capture_pkg::*;
#(
  parameter int unsigned DATA_W     = CAPTURE_DATA_W,
  parameter int unsigned DEPTH      = CAPTURE_DEPTH,
  parameter int unsigned DROP_CNT_W = CAPTURE_DROP_CNT_W
) ();

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                  flush_i;
  logic                  in_valid_i;
  logic [DATA_W-1:0]     in_data_i;
  logic                  in_ready_o;
  logic                  rd_i;
  logic [DATA_W-1:0]     rd_data_o;
  logic                  rd_valid_o;
  logic [ADDR_W:0]       level_o;
  logic                  empty_o;
  logic                  full_o;
  logic                  almost_full_o;
  logic                  overflow_o;
  logic [DROP_CNT_W-1:0] drop_count_o;

  modport master (
    output flush_i, in_valid_i, in_data_i, rd_i,
    input  in_ready_o, rd_data_o, rd_valid_o, level_o, empty_o, full_o,
           almost_full_o, overflow_o, drop_count_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_data_i, rd_i,
    output in_ready_o, rd_data_o, rd_valid_o, level_o, empty_o, full_o,
           almost_full_o, overflow_o, drop_count_o
  );

endinterface

// File: rtl/usb_capture_ram.sv
// Simple dual-port RAM: one write port, one registered read port; only the read register is reset.
module usb_capture_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/usb_capture_fifo.sv
// Capture buffer between the sniffer stream and the register read path: stall/drop full policy,
// sticky overflow, saturating drop counter, almost-full watermark, flush. Option: USB_CAPTURE_FIFO_PEAK_EN.
module usb_capture_fifo
  import usb_capture_pkg::*;
#(
  parameter int unsigned     DATA_W       = CAPTURE_DATA_W,
  parameter int unsigned     DEPTH        = CAPTURE_DEPTH,
  parameter int unsigned     ADDR_W       = $clog2(DEPTH),
  parameter int              AFULL_LEVEL  = int'(DEPTH) - 64,
  parameter capture_policy_e DROP_ON_FULL = CAPTURE_DROP,
  parameter int unsigned     DROP_CNT_W   = CAPTURE_DROP_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef USB_CAPTURE_FIFO_PEAK_EN
  output logic [ADDR_W:0]   peak_level_o,
`endif
  usb_capture_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
  localparam bit              DROP_MODE = (DROP_ON_FULL == CAPTURE_DROP);

  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W:0]       level_q;
  logic [ADDR_W:0]       level_d;
  logic                  empty_q;
  logic                  full_q;
  logic                  afull_q;
  logic                  overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic                  rd_valid_q;
  logic                  wr_en;
  logic                  rd_en;
  logic                  drop_beat;

  // Full/empty are the registered flags, so a same-cycle read never frees a slot for the write.
  always_comb begin
    wr_en     = bus.in_valid_i && !full_q && !bus.flush_i;
    rd_en     = bus.rd_i && !empty_q && !bus.flush_i;
    drop_beat = DROP_MODE && bus.in_valid_i && full_q && !bus.flush_i;
    level_d   = level_q;
    if (bus.flush_i)          level_d = '0;
    else if (wr_en && !rd_en) level_d = level_q + 1'b1;
    else if (!wr_en && rd_en) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      afull_q    <= (AFULL_LEVEL <= 0);
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      empty_q    <= (level_d == '0);
      full_q     <= (level_d == FULL_LVL);
      afull_q    <= (int'(level_d) >= AFULL_LEVEL);
      rd_valid_q <= rd_en;
      if (bus.flush_i) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        if (drop_beat) begin
          overflow_q <= 1'b1;
          if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
      end
    end
  end

  usb_capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.in_data_i),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (bus.rd_data_o)
  );

  assign bus.in_ready_o    = DROP_MODE ? 1'b1 : !full_q;
  assign bus.rd_valid_o    = rd_valid_q;
  assign bus.level_o       = level_q;
  assign bus.empty_o       = empty_q;
  assign bus.full_o        = full_q;
  assign bus.almost_full_o = afull_q;
  assign bus.overflow_o    = overflow_q;
  assign bus.drop_count_o  = drop_cnt_q;

`ifdef USB_CAPTURE_FIFO_PEAK_EN
  logic [ADDR_W:0] peak_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                peak_q <= '0;
    else if (bus.flush_i)       peak_q <= '0;
    else if (level_q > peak_q)  peak_q <= level_q;
  end

  assign peak_level_o = peak_q;
`endif

endmodule

// File: doc/usb_capture_fifo.md
Name: usb_capture_fifo

Overview:
Parametrised capture buffer between the USB sniffer stream core and the register read path; replaces the fixed 32-bit single-mode capture FIFO. Accepts stream beats from the sniffer, holds them in inferred block RAM and returns them one per read strobe with one-cycle latency. Adds a selectable full policy (stall or drop), a sticky overflow flag, a saturating dropped-beat counter, an almost-full watermark and a synchronous flush.

Parameters:
DATA_W, 32, stream/read data width in bits
DEPTH, 8192, entries; power of two, minimum 4
ADDR_W, $clog2(DEPTH), derived pointer width; not overridden
AFULL_LEVEL, DEPTH-64, level at or above which almost_full_o asserts
DROP_ON_FULL, 1, 1 = in_ready_o held high and beats arriving while full are dropped and counted; 0 = in_ready_o = ~full_o (back-pressure)
DROP_CNT_W, 16, dropped-beat counter width

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous clear of contents and status
in_valid_i  in  1  write beat valid
in_data_i  in  DATA_W  write beat data
in_ready_o  out  1  write beat accepted when high with in_valid_i
rd_i  in  1  read strobe
rd_data_o  out  DATA_W  read data, registered
rd_valid_o  out  1  one-cycle pulse: rd_data_o updated this cycle
level_o  out  ADDR_W+1  current entry count, 0..DEPTH
empty_o  out  1  level_o == 0
full_o  out  1  level_o == DEPTH
almost_full_o  out  1  level_o >= AFULL_LEVEL
overflow_o  out  1  sticky: at least one beat dropped since reset/flush
drop_count_o  out  DROP_CNT_W  dropped beats, saturating

Behaviour:
- Reset (rst_ni low, asynchronous): pointers, level_o, rd_valid_o, overflow_o, drop_count_o = 0; rd_data_o = 0; empty_o = 1; in_ready_o = 1. RAM contents are not reset.
- Write: accepted when in_valid_i && !full_o (full_o sampled at start of cycle); data written at wr_ptr, wr_ptr increments modulo DEPTH.
- Full, DROP_ON_FULL=1: in_valid_i beat discarded; overflow_o set next cycle; drop_count_o increments, holds at all-ones.
- Full, DROP_ON_FULL=0: in_ready_o low; no drop, overflow_o and drop_count_o stay 0.
- Read: rd_i && !empty_o -> RAM[rd_ptr] appears on rd_data_o next cycle with rd_valid_o = 1 for that cycle; rd_ptr increments modulo DEPTH. rd_i on empty is ignored: no pointer move, no rd_valid_o, rd_data_o holds.
- rd_data_o holds its last value between reads.
- Simultaneous write and read: both proceed when legal; level_o unchanged. When full, the read frees a slot only for the following cycle; the same-cycle write is not accepted (drop or stall per policy). When empty, the write proceeds, the read is ignored; no write-through.
- level_o, empty_o, full_o, almost_full_o are registered and update the cycle after the causing event.
- Pointer wrap: DEPTH-1 -> 0; level_o tracks count independently of wrap.
- Flush: highest priority; same-cycle read/write ignored; next cycle pointers, level_o, overflow_o, drop_count_o = 0 and rd_valid_o = 0; rd_data_o holds.
- Reset asserted mid-operation: immediate return to reset state; any in-flight read data is lost.

Optional Feature:
USB_CAPTURE_FIFO_PEAK_EN: when defined, adds output peak_level_o (ADDR_W+1) holding the maximum level_o since reset/flush, updated the cycle after level_o, cleared by flush and reset. When undefined, the port and its logic are absent and the block is otherwise identical.

Decomposition:
- Package usb_capture_pkg: default DATA_W, DEPTH, DROP_CNT_W constants; policy encodings CAPTURE_STALL = 0 and CAPTURE_DROP = 1 used for DROP_ON_FULL.
- Sub-module usb_capture_ram: simple dual-port RAM, one write port and one registered read port, parametrised by DATA_W and ADDR_W; no reset on the storage array.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 and read 3 -> rd_data_o 0x11, 0x22, 0x33, each one cycle after rd_i; level_o steps 1, 2, 3 then 2, 1, 0; empty_o ends at 1.
- DEPTH=16, DROP_ON_FULL=1: 20 consecutive writes -> full_o=1, level_o=16, overflow_o=1, drop_count_o=4; readback returns beats 0..15 in order.
- DEPTH=16, DROP_ON_FULL=0: 20 consecutive writes -> in_ready_o low after 16 writes, drop_count_o=0; one read -> in_ready_o high the following cycle and the 17th beat is accepted.
- Full FIFO with simultaneous rd_i and in_valid_i -> read returns the oldest beat; the write is dropped (DROP_ON_FULL=1); level_o goes to 15.
- Steady interleaved write/read across 3xDEPTH beats -> data order preserved through pointer wrap; almost_full_o follows AFULL_LEVEL exactly.
- Flush while level_o=10 with concurrent write and read -> next cycle level_o=0, overflow_o=0, drop_count_o=0, rd_valid_o=0; reset pulse mid-burst -> all outputs at reset values immediately.
